// File: rtl/sim_ctrl_pkg.sv
// Shared constants for the simulation-control responder: register word offsets and run states.
package sim_ctrl_pkg;

   // Word offsets within the 16-byte window (addr[3:2]).
   localparam logic [1:0] OFF_CONSOLE = 2'd0;
   localparam logic [1:0] OFF_EXIT    = 2'd1;
   localparam logic [1:0] OFF_CYC_LO  = 2'd2;
   localparam logic [1:0] OFF_CYC_HI  = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALTED,
      ST_TIMEOUT
   } state_e;

endpackage

// File: rtl/sim_ctrl_responder_if.sv
// Core-side load/store bus seen by the simulation-control responder.
interface sim_ctrl_responder_if;

   logic        mem_we;
   logic        mem_re;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (
      output mem_we, mem_re, addr, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  mem_we, mem_re, addr, wdata,
      output rdata, rvalid
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [Width-1:0]       push_data,
   input  logic                   pop,
   output logic [Width-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(Depth):0] count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = (count_q == CntW'(Depth));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sim_ctrl_responder.sv
// Memory-mapped simulation-control peripheral: console FIFO, 64-bit cycle counter,
// exit register and watchdog, answering core loads/stores with one-cycle read latency.
module sim_ctrl_responder
   import sim_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned WDOG_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                reset,
   sim_ctrl_responder_if.slave bus,
   output logic                char_valid,
   output logic [7:0]          char_data,
   input  logic                char_ready,
   output logic                halted,
   output logic                pass,
   output logic                timeout,
   output logic                overflow
);

   localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [63:0] WdogLast  = 64'(WDOG_CYCLES) - 64'd1;

   logic            hit, rd, wr_console, wr_exit;
   logic [1:0]      off;
   logic            unused_addr;

   state_e          state_q, state_d;
   logic            pass_q, pass_d;
   logic [63:0]     cyc_q, cyc_d;
   logic [31:0]     cyc_hi_q, cyc_hi_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            overflow_q, overflow_d;

   logic            push, pop, fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;

   assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign off         = bus.addr[3:2];
   assign unused_addr = ^bus.addr[1:0];
   assign rd          = bus.mem_re && hit;
   assign wr_console  = bus.mem_we && hit && (off == OFF_CONSOLE);
   assign wr_exit     = bus.mem_we && hit && (off == OFF_EXIT);

   // Console stores are only taken while running; draining continues after halt.
   assign push = wr_console && (state_q == ST_RUN);
   assign pop  = char_valid && char_ready;

   sync_fifo #(
      .Width (8),
      .Depth (FIFO_DEPTH)
   ) u_console_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (bus.wdata[7:0]),
      .pop       (pop),
      .pop_data  (char_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign char_valid = !fifo_empty;
   assign halted     = (state_q != ST_RUN);
   assign timeout    = (state_q == ST_TIMEOUT);
   assign pass       = pass_q && (state_q == ST_HALTED);
   assign overflow   = overflow_q;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;

   always_comb begin
      state_d    = state_q;
      pass_d     = pass_q;
      cyc_d      = cyc_q;
      cyc_hi_d   = cyc_hi_q;
      rdata_d    = rdata_q;
      rvalid_d   = rd;
      overflow_d = overflow_q | (push && fifo_full && !pop);

      unique case (state_q)
         ST_RUN: begin
            cyc_d = cyc_q + 64'd1;
            // An exit store on the watchdog's final cycle takes priority.
            if (wr_exit) begin
               state_d = ST_HALTED;
               pass_d  = (bus.wdata == 32'd0);
            end else if (cyc_q == WdogLast) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: ;
      endcase

      // Reads see pre-write state, so a same-cycle store is not reflected.
      if (rd) begin
         unique case (off)
            OFF_CONSOLE: rdata_d = 32'(fifo_count);
            OFF_EXIT:    rdata_d = {30'd0, timeout, halted};
            OFF_CYC_LO: begin
               rdata_d  = cyc_q[31:0];
               cyc_hi_d = cyc_q[63:32];
            end
            OFF_CYC_HI:  rdata_d = cyc_hi_q;
            default:     rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         pass_q     <= 1'b0;
         cyc_q      <= 64'd0;
         cyc_hi_q   <= 32'd0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pass_q     <= pass_d;
         cyc_q      <= cyc_d;
         cyc_hi_q   <= cyc_hi_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_sim_ctrl_responder.sv
// Directed bench for sim_ctrl_responder: a default instance for bus/FIFO/exit behaviour and a
// short-watchdog instance for timeout and exit-vs-timeout priority.
module tb_sim_ctrl_responder;

   localparam logic [31:0] A_CON  = 32'h0000_7F00;
   localparam logic [31:0] A_EXIT = 32'h0000_7F04;
   localparam logic [31:0] A_LO   = 32'h0000_7F08;
   localparam logic [31:0] A_HI   = 32'h0000_7F0C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       ra = 1'b1, rb = 1'b1;
   logic       rdy_a = 1'b0, rdy_b = 1'b0;
   logic       cv_a, halt_a, pass_a, to_a, ovf_a;
   logic [7:0] cd_a;
   logic       cv_b, halt_b, pass_b, to_b, ovf_b;
   logic [7:0] cd_b;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] d;
   logic [63:0] h;
   logic [63:0] edges = 64'd0;

   sim_ctrl_responder_if bus_a ();
   sim_ctrl_responder_if bus_b ();

   sim_ctrl_responder dut_a (
      .clk        (clk),
      .reset      (ra),
      .bus        (bus_a),
      .char_valid (cv_a),
      .char_data  (cd_a),
      .char_ready (rdy_a),
      .halted     (halt_a),
      .pass       (pass_a),
      .timeout    (to_a),
      .overflow   (ovf_a)
   );

   sim_ctrl_responder #(
      .WDOG_CYCLES (50)
   ) dut_b (
      .clk        (clk),
      .reset      (rb),
      .bus        (bus_b),
      .char_valid (cv_b),
      .char_data  (cd_b),
      .char_ready (rdy_b),
      .halted     (halt_b),
      .pass       (pass_b),
      .timeout    (to_b),
      .overflow   (ovf_b)
   );

   // Edges since dut_a's last reset; equals its counter while it is running.
   always @(posedge clk) edges <= ra ? 64'd0 : edges + 64'd1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic wr_a(input logic [31:0] a, input logic [31:0] v);
      bus_a.mem_we = 1'b1;
      bus_a.addr   = a;
      bus_a.wdata  = v;
      @(negedge clk);
      bus_a.mem_we = 1'b0;
   endtask

   task automatic rd_a(input logic [31:0] a, output logic [31:0] v);
      bus_a.mem_re = 1'b1;
      bus_a.addr   = a;
      @(posedge clk);
      #1;
      check("rvalid_high", bus_a.rvalid, 1);
      v = bus_a.rdata;
      @(negedge clk);
      bus_a.mem_re = 1'b0;
      @(posedge clk);
      #1;
      check("rvalid_one_cycle", bus_a.rvalid, 0);
      @(negedge clk);
   endtask

   task automatic reset_a();
      ra = 1'b1;
      @(negedge clk);
      ra = 1'b0;
   endtask

   initial begin
      bus_a.mem_we = 1'b0; bus_a.mem_re = 1'b0; bus_a.addr = 32'd0; bus_a.wdata = 32'd0;
      bus_b.mem_we = 1'b0; bus_b.mem_re = 1'b0; bus_b.addr = 32'd0; bus_b.wdata = 32'd0;

      // Reset state and idle counting
      repeat (2) @(negedge clk);
      ra = 1'b0;
      check("rst_halted", halt_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_timeout", to_a, 0);
      check("rst_overflow", ovf_a, 0);
      check("rst_char_valid", cv_a, 0);
      check("rst_rvalid", bus_a.rvalid, 0);
      check("rst_rdata", bus_a.rdata, 0);
      repeat (10) @(negedge clk);
      rd_a(A_LO, d);
      check("cyc_lo_idle", d, 10);
      rd_a(A_HI, d);
      check("cyc_hi_idle", d, 0);

      // Console push, simultaneous read/write, then drain
      wr_a(A_CON, 32'h48);
      wr_a(A_CON, 32'h69);
      bus_a.mem_we = 1'b1; bus_a.mem_re = 1'b1; bus_a.addr = A_CON; bus_a.wdata = 32'h21;
      @(posedge clk);
      #1;
      check("rw_same_cycle_pre_value", bus_a.rdata, 2);
      @(negedge clk);
      bus_a.mem_we = 1'b0; bus_a.mem_re = 1'b0;
      rd_a(A_CON, d);
      check("count_3", d, 3);
      check("head_48", cd_a, 8'h48);
      check("valid_nonempty", cv_a, 1);
      rdy_a = 1'b1;
      check("pop0", cd_a, 8'h48);
      @(negedge clk);
      check("pop1", cd_a, 8'h69);
      @(negedge clk);
      check("pop2", cd_a, 8'h21);
      @(negedge clk);
      check("drained_valid", cv_a, 0);
      rdy_a = 1'b0;

      // Full FIFO: push+pop accepted, lone push dropped
      reset_a();
      for (int i = 0; i < 8; i++) wr_a(A_CON, 32'h11 + i);
      rd_a(A_CON, d);
      check("count_full", d, 8);
      check("no_ovf_at_full", ovf_a, 0);
      bus_a.mem_we = 1'b1; bus_a.addr = A_CON; bus_a.wdata = 32'hAA;
      rdy_a = 1'b1;
      @(negedge clk);
      bus_a.mem_we = 1'b0;
      rdy_a = 1'b0;
      check("no_ovf_push_pop", ovf_a, 0);
      wr_a(A_CON, 32'hBB);
      check("ovf_set", ovf_a, 1);
      rd_a(A_CON, d);
      check("count_after_drop", d, 8);
      rdy_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_order", cd_a, (i < 7) ? 8'h12 + 8'(i) : 8'hAA);
         @(negedge clk);
      end
      check("drain_empty", cv_a, 0);
      check("ovf_sticky", ovf_a, 1);
      rdy_a = 1'b0;

      // Exit code 0: halt with pass, counter frozen, console closed
      reset_a();
      wr_a(A_EXIT, 32'd0);
      h = edges;
      check("exit0_halted", halt_a, 1);
      check("exit0_pass", pass_a, 1);
      check("exit0_timeout", to_a, 0);
      wr_a(A_CON, 32'h55);
      check("no_push_halted", cv_a, 0);
      rd_a(A_LO, d);
      check("cyc_frozen", d, h[31:0]);
      rd_a(A_EXIT, d);
      check("exit_reg_halted", d, 1);

      // Exit code 3: halt without pass
      reset_a();
      wr_a(A_EXIT, 32'd3);
      check("exit3_halted", halt_a, 1);
      check("exit3_pass", pass_a, 0);

      // Reset while halted with three queued bytes
      reset_a();
      wr_a(A_CON, 32'h01);
      wr_a(A_CON, 32'h02);
      wr_a(A_CON, 32'h03);
      wr_a(A_EXIT, 32'd0);
      rd_a(A_CON, d);
      check("count_before_reset", d, 3);
      check("halted_before_reset", halt_a, 1);
      reset_a();
      check("rst2_halted", halt_a, 0);
      check("rst2_pass", pass_a, 0);
      check("rst2_char_valid", cv_a, 0);
      check("rst2_overflow", ovf_a, 0);
      check("rst2_rvalid", bus_a.rvalid, 0);
      check("rst2_rdata", bus_a.rdata, 0);
      rd_a(A_LO, d);
      check("cyc_restart0", d, 0);
      rd_a(A_LO, d);
      check("cyc_restart2", d, 2);

      // Watchdog expiry on the short-watchdog instance
      @(negedge clk);
      rb = 1'b0;
      repeat (49) @(negedge clk);
      check("wdog_not_yet", halt_b, 0);
      @(negedge clk);
      check("wdog_halted", halt_b, 1);
      check("wdog_timeout", to_b, 1);
      check("wdog_pass", pass_b, 0);
      bus_b.mem_re = 1'b1; bus_b.addr = A_EXIT;
      @(posedge clk);
      #1;
      check("wdog_exit_reg", bus_b.rdata, 3);
      @(negedge clk);
      bus_b.mem_re = 1'b0;

      // Exit store on the final watchdog cycle wins
      rb = 1'b1;
      @(negedge clk);
      rb = 1'b0;
      repeat (49) @(negedge clk);
      bus_b.mem_we = 1'b1; bus_b.addr = A_EXIT; bus_b.wdata = 32'd0;
      @(negedge clk);
      bus_b.mem_we = 1'b0;
      check("race_halted", halt_b, 1);
      check("race_timeout", to_b, 0);
      check("race_pass", pass_b, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sim_ctrl_responder.md
Name: sim_ctrl_responder

Overview:
- Memory-mapped simulation-control peripheral on the mips data bus; it is the responder to the core's load/store traffic.
- Provides a console byte FIFO, a free-running 64-bit cycle counter, an exit/halt register and a watchdog.
- The bench drains console bytes and watches halt/pass/timeout instead of running a fixed cycle count.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2.
- WDOG_CYCLES, 100000, cycle count at which an un-halted run is declared timed out.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_we  in  1  store strobe from core, valid this cycle.
- mem_re  in  1  load strobe from core.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data, registered, valid the cycle after mem_re.
- rvalid  out  1  high one cycle with rdata.
- char_valid  out  1  console FIFO non-empty.
- char_data  out  8  FIFO head byte.
- char_ready  in  1  bench pops head when char_valid && char_ready.
- halted  out  1  run ended (exit written or timeout).
- pass  out  1  exit code was zero; valid while halted.
- timeout  out  1  watchdog expired.
- overflow  out  1  sticky: a console write was dropped.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Register decode: hit = addr[31:4] == BASE_ADDR[31:4]. Offsets:
  - 0x0 CONSOLE: write pushes wdata[7:0]; read returns FIFO occupancy, zero-extended.
  - 0x4 EXIT: write stores the exit code and halts; read returns {30'b0, timeout, halted}.
  - 0x8 CYC_LO: read only.
  - 0xC CYC_HI: read only; returns the high word latched when CYC_LO was last read.
- Misses and writes to read-only offsets are ignored. A read miss returns rvalid=1 with rdata=0 only if hit; otherwise rvalid stays 0.
- Read latency: exactly one cycle. mem_re and mem_we in the same cycle means the write takes effect and the read returns the pre-write value.
- State machine:
  - RUN to HALTED on an EXIT write; pass = (wdata == 0).
  - RUN to TIMEOUT when the cycle counter == WDOG_CYCLES-1 and no EXIT write occurs that cycle. An EXIT write in that cycle wins.
  - HALTED and TIMEOUT are absorbing until reset.
  - halted = state != RUN; timeout = state == TIMEOUT; pass = 0 in TIMEOUT.
- Cycle counter: 64-bit, increments every cycle in RUN, freezes otherwise. It wraps modulo 2^64, with no special handling.
- Console FIFO:
  - Circular buffer with a count of log2(FIFO_DEPTH)+1 bits.
  - A push when full is dropped and sets overflow, unless a pop happens the same cycle; push and pop together when full are both accepted.
  - Pop when empty: ignored.
  - Pushes are accepted in RUN only. Pops continue after halt so the bench can drain.
  - char_data is the head entry combinationally from the registered array; it is don't-care when empty.
- Reset values: rdata=0, rvalid=0, FIFO empty (char_valid=0), state RUN, counter=0, halted=0, pass=0, timeout=0, overflow=0, latched CYC_HI=0. Reset mid-run discards FIFO contents and the exit code.

Decomposition:
- Shared package sim_ctrl_pkg:
  - Register offset constants OFF_CONSOLE, OFF_EXIT, OFF_CYC_LO, OFF_CYC_HI.
  - State encoding ST_RUN, ST_HALTED, ST_TIMEOUT.
- One natural sub-module: sync_fifo (parameterised width/depth), with push/pop/full/empty/count ports. It is also reusable for a future UART transmitter.

Test Plan:
- Reset for 1 cycle, then idle 10 cycles. Required: halted=0, char_valid=0, read CYC_LO returns 10±1, CYC_HI=0, rvalid exactly one cycle after mem_re.
- Store 0x48, 0x69 to BASE+0 with char_ready=0. Required: count read=2, char_data=0x48. Raise char_ready: 0x48 then 0x69 pop on consecutive cycles, char_valid drops.
- Push 9 bytes with FIFO_DEPTH=8 and char_ready=0. Required: 8 stored, overflow=1. A push with simultaneous pop while full is accepted with no further overflow.
- Store 0 to BASE+4. Required: next cycle halted=1, pass=1, counter frozen, a later console store is not enqueued. Repeat with code 3: pass=0.
- WDOG_CYCLES=50, no EXIT write. Required: timeout=1, halted=1 after cycle 49, pass=0. Also check an EXIT write on cycle 49 gives HALTED, not TIMEOUT.
- Assert reset while in HALTED with 3 FIFO bytes. Required: all outputs return to reset values next cycle and the counter restarts from 0.
